// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: decodes one instruction per handshake into ALU operands and EX side-band.
// Latency 1 cycle into a single output register; InReady = !OutValid | OutReady, outputs hold while stalled.
module alu_issue_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [31:0]      Instr,
    input  logic [XLEN-1:0]  PC,
    output logic [4:0]       Rs1Addr,
    output logic [4:0]       Rs2Addr,
    input  logic [XLEN-1:0]  Rs1Data,
    input  logic [XLEN-1:0]  Rs2Data,
    input  logic             Flush,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [XLEN-1:0]  SrcA,
    output logic [XLEN-1:0]  SrcB,
    output logic [2:0]       ALUControl,
    output logic [2:0]       ALUop,
    output logic [XLEN-1:0]  StoreData,
    output logic [4:0]       Rd,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Branch,
    output logic [XLEN-1:0]  BranchTarget,
    output logic             IllegalInstr,
    output logic [CNT_W-1:0] IssueCount
);

    localparam logic [6:0] OP_REG  = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [31:0]     imm_i, imm_s, imm_b, imm_u;

    logic [XLEN-1:0] srca_d, srcb_d, st_d, bt_d;
    logic [2:0]      ctl_d, aluop_d;
    logic [4:0]      rd_d;
    logic            rw_d, mr_d, mw_d, br_d, ill_d;

    logic [XLEN-1:0] srca_q, srcb_q, st_q, bt_q;
    logic [2:0]      ctl_q, aluop_q;
    logic [4:0]      rd_q;
    logic            rw_q, mr_q, mw_q, br_q, ill_q, valid_q;
    logic [CNT_W-1:0] cnt_q;

    logic            in_xfer, out_xfer;

    assign opcode  = Instr[6:0];
    assign funct3  = Instr[14:12];
    assign funct7  = Instr[31:25];
    assign Rs1Addr = Instr[19:15];
    assign Rs2Addr = Instr[24:20];

    assign imm_i = {{20{Instr[31]}}, Instr[31:20]};
    assign imm_s = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
    assign imm_b = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
    assign imm_u = {Instr[31:12], 12'b0};

    assign InReady  = !valid_q || OutReady;
    assign in_xfer  = InValid && InReady;
    assign out_xfer = valid_q && OutReady;

    always_comb begin
        srca_d  = '0;
        srcb_d  = '0;
        st_d    = '0;
        bt_d    = '0;
        ctl_d   = funct3;
        aluop_d = 3'b000;
        rd_d    = Instr[11:7];
        rw_d    = 1'b0;
        mr_d    = 1'b0;
        mw_d    = 1'b0;
        br_d    = 1'b0;
        ill_d   = 1'b0;
        case (opcode)
            OP_REG: begin
                srca_d = Rs1Data;
                srcb_d = Rs2Data;
                rw_d   = 1'b1;
                if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
                    aluop_d = 3'b001;
                else if (funct7 != 7'b0000000)
                    ill_d = 1'b1;
            end
            OP_IMM: begin
                srca_d = Rs1Data;
                srcb_d = imm_i;
                rw_d   = 1'b1;
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    srcb_d = {27'b0, Instr[24:20]};
                if (funct3 == 3'b001 && funct7 != 7'b0000000)
                    ill_d = 1'b1;
                if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0100000)
                        aluop_d = 3'b001;
                    else if (funct7 != 7'b0000000)
                        ill_d = 1'b1;
                end
            end
            OP_LD: begin
                srca_d  = Rs1Data;
                srcb_d  = imm_i;
                aluop_d = 3'b101;
                ctl_d   = 3'b000;
                mr_d    = 1'b1;
                rw_d    = 1'b1;
            end
            OP_ST: begin
                srca_d  = Rs1Data;
                srcb_d  = imm_s;
                aluop_d = 3'b101;
                ctl_d   = 3'b000;
                mw_d    = 1'b1;
                st_d    = Rs2Data;
                rd_d    = 5'd0;
            end
            OP_BR: begin
                srca_d  = Rs1Data;
                srcb_d  = Rs2Data;
                aluop_d = 3'b010;
                br_d    = 1'b1;
                rd_d    = 5'd0;
                bt_d    = PC + imm_b;
                if (funct3 == 3'b010 || funct3 == 3'b011)
                    ill_d = 1'b1;
            end
            OP_LUI, OP_AUI: begin
                srca_d  = (opcode == OP_AUI) ? PC : '0;
                srcb_d  = imm_u;
                aluop_d = 3'b101;
                ctl_d   = 3'b000;
                rw_d    = 1'b1;
            end
            default: ill_d = 1'b1;
        endcase
        // Illegal encodings still issue, but with an inert payload.
        if (ill_d) begin
            srca_d  = '0;
            srcb_d  = '0;
            st_d    = '0;
            bt_d    = '0;
            ctl_d   = 3'b000;
            aluop_d = 3'b000;
            rd_d    = 5'd0;
            rw_d    = 1'b0;
            mr_d    = 1'b0;
            mw_d    = 1'b0;
            br_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
            srca_q  <= '0;
            srcb_q  <= '0;
            st_q    <= '0;
            bt_q    <= '0;
            ctl_q   <= 3'b000;
            aluop_q <= 3'b000;
            rd_q    <= 5'd0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            br_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            if (out_xfer)
                cnt_q <= cnt_q + CNT_W'(1);
            if (Flush) begin
                valid_q <= 1'b0;
            end else if (in_xfer) begin
                valid_q <= 1'b1;
                srca_q  <= srca_d;
                srcb_q  <= srcb_d;
                st_q    <= st_d;
                bt_q    <= bt_d;
                ctl_q   <= ctl_d;
                aluop_q <= aluop_d;
                rd_q    <= rd_d;
                rw_q    <= rw_d;
                mr_q    <= mr_d;
                mw_q    <= mw_d;
                br_q    <= br_d;
                ill_q   <= ill_d;
            end else if (out_xfer) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign OutValid     = valid_q;
    assign SrcA         = srca_q;
    assign SrcB         = srcb_q;
    assign ALUControl   = ctl_q;
    assign ALUop        = aluop_q;
    assign StoreData    = st_q;
    assign Rd           = rd_q;
    assign RegWrite     = rw_q;
    assign MemRead      = mr_q;
    assign MemWrite     = mw_q;
    assign Branch       = br_q;
    assign BranchTarget = bt_q;
    assign IllegalInstr = ill_q;
    assign IssueCount   = cnt_q;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage that produces every ALU input: SrcA, SrcB, ALUControl, ALUop, plus EX-stage side-band signals.
- Takes one RV32I instruction, its PC and register-file read data per handshake.
- Decodes the instruction, generates the immediate, selects operands and computes the branch target.
- Holds the result in a single output pipeline register with valid/ready flow control and flush.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 32, width of the issued-instruction counter IssueCount; wraps at 2^CNT_W.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- InValid  in  1  upstream holds a valid Instr/PC/Rs1Data/Rs2Data
- InReady  out  1  stage accepts this cycle; = !OutValid | OutReady (combinational)
- Instr  in  32  instruction word
- PC  in  32  address of Instr
- Rs1Addr  out  5  Instr[19:15], combinational, to regfile
- Rs2Addr  out  5  Instr[24:20], combinational, to regfile
- Rs1Data  in  32  regfile data for Rs1Addr, same cycle
- Rs2Data  in  32  regfile data for Rs2Addr, same cycle
- Flush  in  1  kill held and incoming instruction
- OutValid  out  1  output register holds an instruction
- OutReady  in  1  EX consumes this cycle
- SrcA  out  32  ALU operand A
- SrcB  out  32  ALU operand B
- ALUControl  out  3  ALU function select
- ALUop  out  3  ALU op class
- StoreData  out  32  Rs2Data for stores, else 0
- Rd  out  5  destination register
- RegWrite, MemRead, MemWrite, Branch  out  1 each  control flags
- BranchTarget  out  32  PC + B-immediate
- IllegalInstr  out  1  instruction not decodable
- IssueCount  out  CNT_W  count of out-handshakes (OutValid & OutReady)

Behaviour:
- Reset: all registered outputs are 0, including OutValid and IssueCount.
- Transfers: in-transfer = InValid & InReady; out-transfer = OutValid & OutReady.
- On an in-transfer without Flush, the decoded fields load into the output register next edge and OutValid=1. Latency is 1 cycle.
- An out-transfer without a simultaneous in-transfer clears OutValid. A simultaneous in-transfer and out-transfer gives back-to-back issue, 1 instr/cycle.
- While OutValid & !OutReady, all outputs hold stable.
- Flush: next edge OutValid=0; any same-cycle in-transfer is discarded; IssueCount still counts a same-cycle out-transfer. Reset has priority over Flush.
- Decode by opcode Instr[6:0]. Defaults: ALUControl=funct3, flags 0, Rd=Instr[11:7].
  - 0110011 OP: SrcA=Rs1, SrcB=Rs2, RegWrite.
    - funct7=0000000 -> ALUop 000.
    - funct7=0100000 with funct3 000/101 -> ALUop 001.
    - anything else is illegal.
  - 0010011 OP-IMM: SrcA=Rs1, SrcB=sext I-imm, ALUop 000, RegWrite.
    - Shifts (funct3 001/101): SrcB={27'b0,Instr[24:20]}.
    - srai (funct3 101, Instr[31:25]=0100000) -> ALUop 001.
    - slli with funct7≠0, or srli/srai with other funct7, is illegal.
  - 0000011 LOAD: SrcA=Rs1, SrcB=sext I-imm, ALUop 101, ALUControl 000, MemRead, RegWrite.
  - 0100011 STORE: SrcB=sext S-imm {Instr[31:25],Instr[11:7]}, ALUop 101, ALUControl 000, MemWrite, StoreData=Rs2Data, Rd=0.
  - 1100011 BRANCH: SrcA=Rs1, SrcB=Rs2, ALUop 010, ALUControl=funct3, Branch, Rd=0.
    - BranchTarget=PC+sext B-imm {Instr[31],Instr[7],Instr[30:25],Instr[11:8],0}, mod 2^32.
    - funct3 010/011 is illegal.
  - 0110111 LUI: SrcA=0, SrcB={Instr[31:12],12'b0}, ALUop 101, ALUControl 000, RegWrite.
  - 0010111 AUIPC: same as LUI but SrcA=PC.
  - Any other opcode is illegal.
- Illegal instruction: IllegalInstr=1; SrcA, SrcB, StoreData, all flags and Rd are 0; ALUop 000; ALUControl 000. It still issues and is counted.
- BranchTarget is 0 for non-branches.
- IssueCount increments on each out-transfer and wraps to 0.

Test Plan:
- Reset then idle: all outputs 0, InReady=1.
- Feed add x3,x1,x2 (0x002081B3) with Rs1=5, Rs2=7 -> next cycle OutValid=1, SrcA=5, SrcB=7, ALUop=000, ALUControl=000, Rd=3, RegWrite=1.
- sub x3,x1,x2 (0x402081B3) -> ALUop 001. srai x5,x6,4 (0x40435293) -> ALUop 001, ALUControl 101, SrcB=4.
- beq x1,x2,-8 (0xFE208CE3) at PC=0x100 -> Branch=1, ALUop 010, BranchTarget=0xF8.
- sw with 3 cycles OutReady=0 -> outputs stable, InReady=0; then 4 back-to-back instrs with OutReady=1 -> 1/cycle, IssueCount +4.
- Flush while OutValid=1 and an in-transfer occurs -> OutValid=0 next cycle; opcode 0x7F -> IllegalInstr=1, SrcA=SrcB=0.
